// File: rtl/load_store_unit.sv
// Load/store unit: RISC-V loads and stores mapped onto a word-wide memory,
// with read-modify-write for sub-word stores and fault detection.
module load_store_unit #(
   parameter int unsigned ADDR_LIMIT = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic        mem_should_write,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [2:0] {
      IDLE, LOAD, READ, WRITE, DONE
   } state_t;

   state_t      state, next;
   logic        is_store_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [15:0] wdata_q;
   logic [31:0] merge_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        bad_f3, misal, oor, fault;
   logic [4:0]  sh;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] ext;
   logic [31:0] lane_mask, lane_data, merged;

   always_comb begin
      if (req_is_store)
         bad_f3 = req_funct3[2] | (req_funct3[1:0] == 2'b11);
      else
         bad_f3 = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
      misal = (req_funct3[1:0] == 2'b01 && req_addr[0])
            || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
      oor   = req_addr >= ADDR_LIMIT;
      fault = bad_f3 | misal | oor;
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else        state <= next;

   always_comb begin
      next             = state;
      req_ready        = 1'b0;
      resp_valid       = 1'b0;
      mem_should_write = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (fault)                       next = DONE;
               else if (!req_is_store)          next = LOAD;
               else if (req_funct3[1:0] == 2'b10) next = WRITE;
               else                             next = READ;
            end
         end
         LOAD:  next = DONE;
         READ:  next = WRITE;
         WRITE: begin
            mem_should_write = 1'b1;
            next = DONE;
         end
         DONE: begin
            resp_valid = 1'b1;
            if (resp_ready) next = IDLE;
         end
         default: next = IDLE;
      endcase
   end

   // Lane selection and extension of the word read from memory.
   always_comb begin
      sh = {addr_q[1:0], 3'b000};
      case (addr_q[1:0])
         2'd0:    lane_b = mem_read_data[7:0];
         2'd1:    lane_b = mem_read_data[15:8];
         2'd2:    lane_b = mem_read_data[23:16];
         default: lane_b = mem_read_data[31:24];
      endcase
      lane_h = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
      case (f3_q)
         3'b000:  ext = {{24{lane_b[7]}}, lane_b};
         3'b001:  ext = {{16{lane_h[15]}}, lane_h};
         3'b100:  ext = {24'b0, lane_b};
         3'b101:  ext = {16'b0, lane_h};
         default: ext = mem_read_data;
      endcase
      lane_mask = (f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
      lane_data = (f3_q[0] ? {16'b0, wdata_q} : {24'b0, wdata_q[7:0]}) << sh;
      merged    = (mem_read_data & ~lane_mask) | lane_data;
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         is_store_q <= 1'b0;
         f3_q       <= 3'b0;
         addr_q     <= 32'b0;
         wdata_q    <= 16'b0;
         merge_q    <= 32'b0;
         rdata_q    <= 32'b0;
         err_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               is_store_q <= req_is_store;
               f3_q       <= req_funct3;
               wdata_q    <= req_wdata[15:0];
               err_q      <= fault;
               rdata_q    <= 32'b0;
               // Faulting requests leave the memory address untouched.
               if (!fault) addr_q <= req_addr;
               if (!fault && req_is_store) merge_q <= req_wdata;
            end
            LOAD: rdata_q <= is_store_q ? 32'b0 : ext;
            READ: merge_q <= merged;
            default: ;
         endcase
      end

   assign mem_addr       = {addr_q[31:2], 2'b00};
   assign mem_write_data = merge_q;
   assign resp_rdata     = rdata_q;
   assign resp_err       = err_q && (state == DONE);

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute stage and the unified instruction/data memory.
- Turns RISC-V load and store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-wide memory accesses.
- Sign- or zero-extends load data.
- Performs a read-modify-write for byte and halfword stores, because the memory only writes whole words.
- Detects misaligned, out-of-range and illegal-width requests, and completes them with an error and no memory access.

Parameters:
- ADDR_LIMIT, 4096, byte-address bound; any access with addr >= ADDR_LIMIT is an error.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- req_valid  input  1  core presents a request
- req_ready  output  1  unit can accept a request
- req_is_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V width/sign encoding
- req_addr  input  32  byte address
- req_wdata  input  32  store data; low bytes used for SB/SH
- resp_valid  output  1  response available
- resp_ready  input  1  core accepts the response
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  request faulted
- mem_addr  output  32  byte address to memory
- mem_should_write  output  1  memory write enable
- mem_write_data  output  32  full word to write
- mem_read_data  input  32  combinational read of word at mem_addr

Behaviour:
- Reset (reset=0, asynchronous), applied at any time including mid-operation:
  - state=IDLE
  - all latched registers cleared
  - resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_should_write=0, mem_write_data=0
  - an in-flight request is dropped with no write issued.
- Outputs are Moore-decoded from state and registers, so mem_should_write and mem_write_data are stable for the whole cycle, covering memory's negedge write.
- States:
  - IDLE: req_ready=1. On posedge with req_valid=1, latch is_store, funct3, addr and wdata, then classify the request:
    - Error when any of:
      - load funct3 in {011,110,111}
      - store funct3 not in {000,001,010}
      - halfword with addr[0]=1
      - word with addr[1:0]!=0
      - addr >= ADDR_LIMIT
    - Next state by class:
      - error -> DONE, with resp_err=1 and resp_rdata=0
      - load -> LOAD
      - SW -> WRITE, with merge word = wdata
      - SB/SH -> READ
  - LOAD: mem_addr = {addr[31:2],2'b00}.
    - Select the byte/halfword by addr[1:0] and extend it: funct3[2]=0 sign-extends, funct3[2]=1 zero-extends. LW passes the word through.
    - Register the result into resp_rdata -> DONE.
  - READ: mem_addr as in LOAD.
    - Register the merge word = mem_read_data with the addressed lane(s) replaced by wdata[7:0] (byte) or wdata[15:0] (halfword) -> WRITE.
  - WRITE: mem_addr as in LOAD, mem_should_write=1, mem_write_data = merge word -> DONE.
  - DONE: resp_valid=1 and resp_err as latched.
    - Hold until resp_ready=1, then -> IDLE.
    - req_ready=0 while in DONE.
- Outside the WRITE state, mem_should_write=0. mem_addr keeps its last value; there is no glitching to 0 between states.
- Latency, request accepted at posedge N:
  - load or error: resp_valid from N+2 (error from N+1)
  - SW: write lands in cycle N+1, resp_valid from N+2
  - SB/SH: write lands in cycle N+2, resp_valid from N+3
- Back-to-back: a new request is accepted only in IDLE, so at most one request is outstanding. An RMW cannot interleave with another access.
- resp_rdata is 0 for every store response.

Test Plan:
- Word 0x100 = 0x8899AABB; LB addr 0x101 -> resp_rdata=0xFFFFFFAA, resp_err=0, resp_valid 2 cycles after accept. LBU at the same address -> 0x000000AA.
- Word 0x200 = 0x11223344; SB addr 0x202, wdata 0xDEADBEEF -> exactly one write cycle with mem_write_data=0x11EF3344; a subsequent LW 0x200 returns 0x11EF3344.
- SH addr 0x203 -> resp_err=1, mem_should_write never asserted, resp_valid 1 cycle after accept. LW 0x1000 with default ADDR_LIMIT -> resp_err=1.
- SW addr 0x40, wdata 0xCAFEF00D with resp_ready held 0 for 3 cycles -> resp_valid stays 1 and req_ready stays 0 until resp_ready=1, then IDLE.
- Assert reset low during the READ state of an SB -> outputs go to 0 immediately, no write is issued, the target word is unchanged, and req_ready=1 after release.
- LH addr 0x102 on word 0x7FFF0000 -> 0x00007FFF. LH addr 0x100 on word 0x00008000 -> 0xFFFF8000.
